// File: rtl/token_frame_counter.sv
// Counts '1' tokens over frames of FRAME_LEN enabled samples and hands each count out on a
// one-entry valid/ready register. Define TOKEN_FRAME_COUNTER_RUNLEN_EN to add the max_run output.
module token_frame_counter #(
    parameter  int FRAME_LEN = 8,
    localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             a,
    output logic [CNT_W-1:0] cnt,
    output logic             cnt_vld,
    input  logic             cnt_rdy,
    output logic             overrun
`ifdef TOKEN_FRAME_COUNTER_RUNLEN_EN
    ,
    output logic [CNT_W-1:0] max_run
`endif
);

    localparam int               POS_W    = $clog2(FRAME_LEN);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(FRAME_LEN - 1);

    logic [POS_W-1:0] r_pos;
    logic [CNT_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cnt_vld;
    logic             r_overrun;

    logic             w_frame_end;
    logic [CNT_W-1:0] w_final;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    assign w_frame_end = en && (r_pos == LAST_POS);
    assign w_final     = r_acc + CNT_W'(a);
    assign w_pop       = r_cnt_vld && cnt_rdy;
    // A consumer taking the held count on the frame-end cycle frees the slot for the new one.
    assign w_push      = w_frame_end && (!r_cnt_vld || cnt_rdy);
    assign w_drop      = w_frame_end && r_cnt_vld && !cnt_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pos     <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_cnt_vld <= 1'b0;
            r_overrun <= 1'b0;
        end else if (clr) begin
            r_pos     <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_cnt_vld <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (en) begin
                if (w_frame_end) begin
                    r_pos <= '0;
                    r_acc <= '0;
                end else begin
                    r_pos <= r_pos + POS_W'(1);
                    r_acc <= w_final;
                end
            end
            if (w_push) begin
                r_cnt     <= w_final;
                r_cnt_vld <= 1'b1;
            end else if (w_pop) begin
                r_cnt_vld <= 1'b0;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign cnt     = r_cnt;
    assign cnt_vld = r_cnt_vld;
    assign overrun = r_overrun;

`ifdef TOKEN_FRAME_COUNTER_RUNLEN_EN
    logic [CNT_W-1:0] r_run;
    logic [CNT_W-1:0] r_max;
    logic [CNT_W-1:0] r_max_run;
    logic [CNT_W-1:0] w_run_next;
    logic [CNT_W-1:0] w_max_next;

    // Only enabled samples touch the run state, so en=0 gaps neither break nor extend a run.
    assign w_run_next = a ? (r_run + CNT_W'(1)) : '0;
    assign w_max_next = (w_run_next > r_max) ? w_run_next : r_max;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run     <= '0;
            r_max     <= '0;
            r_max_run <= '0;
        end else if (clr) begin
            r_run     <= '0;
            r_max     <= '0;
            r_max_run <= '0;
        end else begin
            if (en) begin
                if (w_frame_end) begin
                    r_run <= '0;
                    r_max <= '0;
                end else begin
                    r_run <= w_run_next;
                    r_max <= w_max_next;
                end
            end
            if (w_push) begin
                r_max_run <= w_max_next;
            end
        end
    end

    assign max_run = r_max_run;
`endif

endmodule

// File: tb/tb_token_frame_counter.sv
// Directed bench for token_frame_counter (FRAME_LEN=8); expected counts are queued when a frame
// is driven and popped when the DUT presents them.
module tb_token_frame_counter;

    localparam int FRAME_LEN = 8;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             clr = 1'b0;
    logic             en = 1'b0;
    logic             a = 1'b0;
    logic             cnt_rdy = 1'b0;
    logic [CNT_W-1:0] cnt;
    logic             cnt_vld;
    logic             overrun;
`ifdef TOKEN_FRAME_COUNTER_RUNLEN_EN
    logic [CNT_W-1:0] max_run;
`endif

    token_frame_counter #(.FRAME_LEN(FRAME_LEN)) dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .en      (en),
        .a       (a),
        .cnt     (cnt),
        .cnt_vld (cnt_vld),
        .cnt_rdy (cnt_rdy),
        .overrun (overrun)
`ifdef TOKEN_FRAME_COUNTER_RUNLEN_EN
        ,
        .max_run (max_run)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int run;
    } exp_t;

    exp_t sb[$];
    int   n_err = 0;
    int   n_chk = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic i_en, input logic i_a, input logic i_rdy);
        en      = i_en;
        a       = i_a;
        cnt_rdy = i_rdy;
        step();
    endtask

    task automatic send_bits(input logic [7:0] bits, input int nbits, input logic i_rdy);
        for (int i = 0; i < nbits; i++) begin
            drive(1'b1, bits[7-i], i_rdy);
        end
    endtask

    task automatic expect_push(input int c, input int r);
        sb.push_back('{c, r});
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        chk({tag, "_vld"}, 32'(cnt_vld), 32'd1);
        n_chk++;
        assert (sb.size() != 0) else begin
            n_err++;
            $error("FAIL %s_sb: observed=output expected=no_output", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_cnt"}, 32'(cnt), 32'(e.cnt));
`ifdef TOKEN_FRAME_COUNTER_RUNLEN_EN
            chk({tag, "_run"}, 32'(max_run), 32'(e.run));
`endif
        end
    endtask

    initial begin
        step();
        step();
        rst = 1'b1;

        // Reset: build a held count and a partial frame, then reset asynchronously mid-cycle.
        send_bits(8'hFF, 8, 1'b0);
        expect_push(8, 8);
        check_out("pre_reset");
        send_bits(8'hE0, 3, 1'b0);
        en  = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_vld", 32'(cnt_vld), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
`ifdef TOKEN_FRAME_COUNTER_RUNLEN_EN
        chk("rst_run", 32'(max_run), 32'd0);
`endif
        step();
        #2;
        rst = 1'b1;
        step();

        // Basic frame 1011_0011 -> 5, then 0000_0000 -> 0.
        send_bits(8'hB3, 7, 1'b1);
        chk("basic_early_vld", 32'(cnt_vld), 32'd0);
        expect_push(5, 2);
        drive(1'b1, 1'b1, 1'b1);
        check_out("basic5");
        drive(1'b1, 1'b0, 1'b1);
        chk("basic_pop_vld", 32'(cnt_vld), 32'd0);
        chk("basic_pop_hold", 32'(cnt), 32'd5);
        send_bits(8'h00, 7, 1'b1);
        expect_push(0, 0);
        check_out("basic0");

        // en gating: a=1 throughout, en high on 8 of 14 cycles.
        begin
            logic [13:0] pat;
            pat = 14'b10110011010011;
            for (int i = 0; i < 14; i++) begin
                if (i == 13) expect_push(8, 8);
                drive(pat[13-i], 1'b1, 1'b1);
                if (i == 12) chk("engate_early_vld", 32'(cnt_vld), 32'd0);
            end
        end
        check_out("engate");
        drive(1'b0, 1'b0, 1'b1);
        chk("engate_pop_vld", 32'(cnt_vld), 32'd0);

        // Backpressure: second frame completes while the first is unconsumed.
        send_bits(8'hFF, 8, 1'b0);
        expect_push(8, 8);
        check_out("bp_first");
        chk("bp_ovr0", 32'(overrun), 32'd0);
        send_bits(8'hE0, 8, 1'b0);
        chk("bp_drop_vld", 32'(cnt_vld), 32'd1);
        chk("bp_drop_cnt", 32'(cnt), 32'd8);
        chk("bp_drop_ovr", 32'(overrun), 32'd1);
`ifdef TOKEN_FRAME_COUNTER_RUNLEN_EN
        chk("bp_drop_run", 32'(max_run), 32'd8);
`endif
        drive(1'b0, 1'b0, 1'b1);
        chk("bp_acc_vld", 32'(cnt_vld), 32'd0);
        chk("bp_acc_ovr", 32'(overrun), 32'd1);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("bp_sticky_ovr", 32'(overrun), 32'd1);
        clr = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        clr = 1'b0;
        chk("clr_ovr", 32'(overrun), 32'd0);
        chk("clr_vld", 32'(cnt_vld), 32'd0);
        chk("clr_cnt", 32'(cnt), 32'd0);

        // Simultaneous pop and push at a frame end.
        send_bits(8'h0F, 8, 1'b0);
        expect_push(4, 4);
        check_out("pp_first");
        send_bits(8'h7E, 7, 1'b0);
        chk("pp_stable_cnt", 32'(cnt), 32'd4);
        expect_push(6, 6);
        drive(1'b1, 1'b0, 1'b1);
        check_out("pp_second");
        chk("pp_ovr", 32'(overrun), 32'd0);
        drive(1'b0, 1'b0, 1'b1);
        chk("pp_pop_vld", 32'(cnt_vld), 32'd0);

        // clr mid-frame with a pending count and overrun set.
        send_bits(8'hFF, 8, 1'b0);
        expect_push(8, 8);
        check_out("cm_pend");
        send_bits(8'hFF, 8, 1'b0);
        chk("cm_ovr_set", 32'(overrun), 32'd1);
        send_bits(8'hB0, 5, 1'b0);
        clr = 1'b1;
        drive(1'b1, 1'b1, 1'b1);
        clr = 1'b0;
        chk("cm_vld", 32'(cnt_vld), 32'd0);
        chk("cm_ovr", 32'(overrun), 32'd0);
        chk("cm_cnt", 32'(cnt), 32'd0);
        send_bits(8'hFF, 7, 1'b1);
        chk("cm_early_vld", 32'(cnt_vld), 32'd0);
        expect_push(8, 8);
        drive(1'b1, 1'b1, 1'b1);
        check_out("cm_frame");
        drive(1'b0, 1'b0, 1'b1);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/token_frame_counter.md
Name: token_frame_counter

Overview:
- Downstream consumer of the serial token stream produced by the token-halving stage; samples one bit per enabled cycle.
- Counts '1' tokens over fixed frames of FRAME_LEN enabled cycles and hands each frame's count to a parallel consumer over a valid/ready interface.
- One-entry output register; frames completing while it is still occupied are dropped and flagged.

Parameters:
- FRAME_LEN, 8, enabled cycles per frame; legal range 2..1024.
- CNT_W, $clog2(FRAME_LEN+1), width of count output; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset; port named rst, asserted when 0.
- clr  input  1  synchronous clear; restarts frame, empties output, clears overrun.
- en  input  1  sample qualifier; a is sampled only when en=1.
- a  input  1  serial token bit.
- cnt  output  CNT_W  token count of completed frame; valid only when cnt_vld=1.
- cnt_vld  output  1  output register holds an unconsumed count.
- cnt_rdy  input  1  consumer accepts cnt when cnt_vld & cnt_rdy.
- overrun  output  1  sticky; a completed frame was dropped.

Behaviour:
- Reset (rst=0, async): pos=0, acc=0, cnt=0, cnt_vld=0, overrun=0; all regs cleared immediately, not at the next edge.
- State: pos (0..FRAME_LEN-1) position within frame; acc (CNT_W) tokens so far in frame.
- Priority per cycle: clr > frame logic. clr=1: pos=0, acc=0, cnt_vld=0, cnt=0, overrun=0 next cycle; a and cnt_rdy ignored that cycle.
- en=0: pos and acc hold; a ignored; output handshake still operates.
- en=1, pos<FRAME_LEN-1: pos+=1, acc+=a.
- en=1, pos==FRAME_LEN-1 (frame end): final=acc+a; pos=0, acc=0 next cycle. Final never exceeds FRAME_LEN, so no overflow in CNT_W.
- Push at frame end: if output is empty, or it is occupied and cnt_rdy=1 this same cycle, then cnt=final and cnt_vld=1 next cycle. Simultaneous pop+push causes no overrun and no bubble.
- Drop at frame end: if cnt_vld=1 and cnt_rdy=0, final is discarded, held cnt unchanged, overrun=1 next cycle.
- overrun stays set until clr or reset.
- Pop: cnt_vld & cnt_rdy with no push gives cnt_vld=0 next cycle; cnt holds its last value.
- cnt_rdy while cnt_vld=0 has no effect.
- Latency: count appears on cnt with cnt_vld=1 on the cycle after the frame's last sampled bit.
- cnt is stable while cnt_vld=1 and not accepted.
- Back-to-back frames with cnt_rdy tied 1: one count every FRAME_LEN enabled cycles, none lost.

Optional Feature:
- Macro: TOKEN_FRAME_COUNTER_RUNLEN_EN.
- Enabled: extra output port max_run (CNT_W): longest run of consecutive sampled '1's within the frame.
- Runs are counted over enabled samples only; en=0 cycles neither break nor extend a run.
- Runs do not carry across frame boundaries.
- max_run is loaded, held, reset and cleared exactly alongside cnt, using the same push/drop rules.
- Disabled: port and run-tracking logic are absent; all other behaviour is identical.

Test Plan:
- Reset/idle: hold rst=0 mid-frame after 3 tokens, release -> cnt_vld=0, cnt=0, overrun=0; next frame starts at pos 0.
- Basic frame (FRAME_LEN=8, cnt_rdy=1, en=1): a=1011_0011 -> cnt=5, cnt_vld=1 for one cycle after bit 8; next frame a=0000_0000 -> cnt=0.
- en gating: a=1 every cycle, en high on 8 of 14 cycles -> single cnt=8 after the 8th enabled cycle; pos holds while en=0.
- Backpressure/overrun: cnt_rdy=0 across two frames of 8 ones then 3 ones -> cnt stays 8, overrun=1 after second frame end; assert cnt_rdy -> accepted, cnt_vld=0; overrun stays 1 until clr.
- Simultaneous pop+push: cnt_vld=1 holding 4, cnt_rdy=1 on next frame-end cycle with final=6 -> cnt=6, cnt_vld=1 next cycle, overrun=0.
- clr mid-frame: after 5 bits with acc=3, pulse clr -> following 8 ones give cnt=8, not 11; a pending count and overrun are cleared.
